// File: rtl/c_align_buffer_if.sv
// c_align_buffer_if: fetch-side and decode-side handshake bundle for c_align_buffer.
// slave is the buffer's view, master is the driver/consumer view.
interface c_align_buffer_if #(
    parameter int FETCH_HW = 2,
    parameter int DEPTH_HW = 8
);
    logic                        flush_i;
    logic [31:0]                 flush_pc_i;
    logic                        fetch_valid_i;
    logic                        fetch_ready_o;
    logic [16*FETCH_HW-1:0]      fetch_data_i;
    logic                        inst_valid_o;
    logic                        inst_ready_i;
    logic [31:0]                 inst_o;
    logic [31:0]                 inst_pc_o;
    logic                        inst_is_comp_o;
    logic [$clog2(DEPTH_HW):0]   count_o;

    modport slave (
        input  flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
        output fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o, count_o
    );

    modport master (
        output flush_i, flush_pc_i, fetch_valid_i, fetch_data_i, inst_ready_i,
        input  fetch_ready_o, inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o, count_o
    );
endinterface

// File: rtl/c_align_buffer.sv
// c_align_buffer: halfword FIFO that realigns fetch words into 16/32-bit instructions.
// Define C_ALIGN_COMP_EN to accept compressed (16-bit) instructions.
module c_align_buffer #(
    parameter int FETCH_HW = 2,
    parameter int DEPTH_HW = 8
) (
    input logic              clk,
    input logic              reset,
    c_align_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_HW);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(FETCH_HW);

    logic [15:0]   mem [DEPTH_HW];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt, count, need;
    logic [SW-1:0] skip, skip_in;
    logic [31:0]   pc, pc_in, inst, held_inst;
    logic [15:0]   h0, h1;
    logic          comp, held_comp, valid, fetch_ready, push, pop;

    always_comb begin
        count = wr_ptr - rd_ptr;
        rd_nxt = rd_ptr + PW'(1);
        h0 = mem[rd_ptr[AW-1:0]];
        h1 = mem[rd_nxt[AW-1:0]];
`ifdef C_ALIGN_COMP_EN
        comp = h0[1:0] != 2'b11;
        pc_in = {bus.flush_pc_i[31:1], 1'b0};
        skip_in = bus.flush_pc_i[SW:1];
`else
        comp = 1'b0;
        pc_in = {bus.flush_pc_i[31:2], 2'b00};
        skip_in = bus.flush_pc_i[SW:1] & ~SW'(1);
`endif
        need = comp ? PW'(1) : PW'(2);
        valid = count >= need;
        inst = comp ? {16'h0000, h0} : {h1, h0};
        fetch_ready = !bus.flush_i && count <= PW'(DEPTH_HW - FETCH_HW);
        push = bus.fetch_valid_i && fetch_ready;
        pop = valid && bus.inst_ready_i && !bus.flush_i;
    end

    assign bus.fetch_ready_o = fetch_ready;
    assign bus.count_o = count;
    assign bus.inst_valid_o = valid;
    assign bus.inst_pc_o = pc;
    assign bus.inst_o = valid ? inst : held_inst;
    assign bus.inst_is_comp_o = valid ? comp : held_comp;

    // halfwords below the post-flush entry point are dropped, the rest pack from wr_ptr
    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < FETCH_HW; i++)
                if (i >= int'(skip))
                    mem[AW'(wr_ptr + PW'(i) - PW'(skip))] <= bus.fetch_data_i[16*i +: 16];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            skip <= '0;
            pc <= '0;
            held_inst <= '0;
            held_comp <= 1'b0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            skip <= skip_in;
            pc <= pc_in;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(FETCH_HW) - PW'(skip);
                skip <= '0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + need;
                pc <= pc + (32'(need) << 1);
            end
            if (valid) begin
                held_inst <= inst;
                held_comp <= comp;
            end
        end
    end
endmodule

// File: tb/tb_c_align_buffer.sv
// tb_c_align_buffer: directed + streaming checks of c_align_buffer against a halfword-queue
// reference model; expected instructions are queued on push and compared at the head.
module tb_c_align_buffer;
    localparam int FH = 2;
    localparam int DH = 8;
`ifdef C_ALIGN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        comp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        checks_on = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          mcount = 0;
    int          mskip = 0;
    logic [31:0] mpc = '0;
    logic [15:0] hq[$];
    exp_t        exp_q[$];
    logic [15:0] a, b;

    c_align_buffer_if #(.FETCH_HW(FH), .DEPTH_HW(DH)) bus ();
    c_align_buffer #(.FETCH_HW(FH), .DEPTH_HW(DH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set(input logic f, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] d, input logic rdy);
        bus.flush_i = f;
        bus.flush_pc_i = fpc;
        bus.fetch_valid_i = fv;
        bus.fetch_data_i = d;
        bus.inst_ready_i = rdy;
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] h;
        bit more = 1'b1;
        while (more && hq.size() > 0) begin
            h = hq[0];
            if (COMP && h[1:0] != 2'b11) begin
                e.inst = {16'h0000, h};
                e.pc = mpc;
                e.comp = 1'b1;
                void'(hq.pop_front());
                mpc += 2;
                exp_q.push_back(e);
            end else if (hq.size() >= 2) begin
                e.inst = {hq[1], h};
                e.pc = mpc;
                e.comp = 1'b0;
                void'(hq.pop_front());
                void'(hq.pop_front());
                mpc += 4;
                exp_q.push_back(e);
            end else
                more = 1'b0;
        end
    endtask

    task automatic tick();
        exp_t e;
        bit acc;
        @(negedge clk);
        if (checks_on) begin
            chk("count", 32'(bus.count_o), mcount);
            chk("valid", 32'(bus.inst_valid_o), 32'(exp_q.size() > 0));
            chk("fetch_ready", 32'(bus.fetch_ready_o), 32'(!bus.flush_i && mcount <= DH - FH));
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("inst", bus.inst_o, e.inst);
                chk("inst_pc", bus.inst_pc_o, e.pc);
                chk("is_comp", 32'(bus.inst_is_comp_o), 32'(e.comp));
            end
        end
        if (reset) begin
            hq.delete();
            exp_q.delete();
            mcount = 0;
            mskip = 0;
            mpc = '0;
        end else if (bus.flush_i) begin
            hq.delete();
            exp_q.delete();
            mcount = 0;
            mskip = int'(bus.flush_pc_i[$clog2(2*FH)-1:1]);
            if (!COMP) mskip = mskip & ~1;
            mpc = COMP ? {bus.flush_pc_i[31:1], 1'b0} : {bus.flush_pc_i[31:2], 2'b00};
        end else begin
            acc = bus.fetch_valid_i && mcount <= DH - FH;
            if (exp_q.size() > 0 && bus.inst_ready_i) begin
                e = exp_q.pop_front();
                mcount -= e.comp ? 1 : 2;
            end
            if (acc) begin
                for (int i = mskip; i < FH; i++) hq.push_back(bus.fetch_data_i[16*i +: 16]);
                mcount += FH - mskip;
                mskip = 0;
                drain();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set(1'b0, '0, 1'b0, '0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        checks_on = 1'b1;
        chk("rst_count", 32'(bus.count_o), 0);
        chk("rst_valid", 32'(bus.inst_valid_o), 0);
        chk("rst_fetch_ready", 32'(bus.fetch_ready_o), 1);
        chk("rst_pc", bus.inst_pc_o, 0);

        // single word with a compressed head
        set(1'b0, '0, 1'b1, 32'h0000_4501, 1'b0);
        tick();
        set(1'b0, '0, 1'b0, '0, 1'b0);
        chk("c_valid", 32'(bus.inst_valid_o), 1);
        chk("c_inst", bus.inst_o, 32'h0000_4501);
        chk("c_is_comp", 32'(bus.inst_is_comp_o), 32'(COMP));
        chk("c_pc", bus.inst_pc_o, 0);
        tick();
        bus.inst_ready_i = 1'b1;
        tick();
        chk("c_pc_step", bus.inst_pc_o, COMP ? 32'h2 : 32'h4);
        repeat (2) tick();

        // redirect into the middle of a fetch word
        set(1'b1, 32'h0000_0102, 1'b0, '0, 1'b0);
        tick();
        chk("fl_pc", bus.inst_pc_o, COMP ? 32'h102 : 32'h100);
        chk("fl_count", 32'(bus.count_o), 0);
        set(1'b0, '0, 1'b1, 32'h0093_dead, 1'b0);
        tick();
        if (COMP) chk("fl_half_invalid", 32'(bus.inst_valid_o), 0);
        set(1'b0, '0, 1'b1, 32'h1234_0010, 1'b0);
        tick();
        bus.fetch_valid_i = 1'b0;
        if (COMP) begin
            chk("fl_valid", 32'(bus.inst_valid_o), 1);
            chk("fl_inst", bus.inst_o, 32'h0010_0093);
            chk("fl_inst_pc", bus.inst_pc_o, 32'h102);
            chk("fl_is_comp", 32'(bus.inst_is_comp_o), 0);
        end
        bus.inst_ready_i = 1'b1;
        repeat (4) tick();

        // fill to capacity, then watch fetch_ready recover
        set(1'b1, '0, 1'b0, '0, 1'b0);
        tick();
        bus.flush_i = 1'b0;
        bus.fetch_valid_i = 1'b1;
        for (int k = 0; k < 20 && mcount <= DH - FH; k++) begin
            bus.fetch_data_i = {16'(k * 8 + 5), 16'(k * 8 + 1)};
            tick();
        end
        bus.fetch_valid_i = 1'b0;
        chk("full_count", 32'(bus.count_o), DH);
        chk("full_fetch_ready", 32'(bus.fetch_ready_o), 0);
        bus.inst_ready_i = 1'b1;
        tick();
        bus.inst_ready_i = 1'b0;
        chk("pop1_count", 32'(bus.count_o), COMP ? DH - 1 : DH - 2);
        chk("pop1_fetch_ready", 32'(bus.fetch_ready_o), 32'(!COMP));
        tick();
        bus.inst_ready_i = 1'b1;
        tick();
        chk("pop2_fetch_ready", 32'(bus.fetch_ready_o), 1);
        repeat (8) tick();

        // streaming mixed-length traffic across pointer wrap
        set(1'b1, 32'h0000_0006, 1'b0, '0, 1'b0);
        tick();
        set(1'b0, '0, 1'b1, '0, 1'b1);
        for (int k = 0; k < 60; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) b[1:0] = 2'b11;
            bus.fetch_data_i = {b, a};
            tick();
        end

        // flush against a live push and pop
        set(1'b1, 32'h0000_0010, 1'b1, 32'h0001_0001, 1'b1);
        tick();
        set(1'b0, '0, 1'b0, '0, 1'b0);
        chk("flpp_count", 32'(bus.count_o), 0);
        chk("flpp_valid", 32'(bus.inst_valid_o), 0);
        chk("flpp_pc", bus.inst_pc_o, 32'h10);
        tick();

        // reset beats flush and discards a partial instruction
        set(1'b1, 32'h0000_0002, 1'b0, '0, 1'b0);
        tick();
        set(1'b0, '0, 1'b1, 32'h0093_0017, 1'b0);
        tick();
        reset = 1'b1;
        set(1'b1, 32'h0000_0040, 1'b1, 32'h0001_0001, 1'b1);
        tick();
        reset = 1'b0;
        set(1'b0, '0, 1'b0, '0, 1'b0);
        chk("mrst_count", 32'(bus.count_o), 0);
        chk("mrst_valid", 32'(bus.inst_valid_o), 0);
        chk("mrst_pc", bus.inst_pc_o, 0);
        set(1'b0, '0, 1'b1, 32'h0000_4501, 1'b0);
        tick();
        bus.fetch_valid_i = 1'b0;
        chk("mrst_inst", bus.inst_o, 32'h0000_4501);
        bus.inst_ready_i = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/c_align_buffer.md
C_ALIGN_BUFFER -- requirements
Module: c_align_buffer

Interface
REQ-001 Parameter FETCH_HW, default 2: 16-bit halfwords per fetch word; legal values 2 and 4.
REQ-002 Parameter DEPTH_HW, default 8: buffer capacity in halfwords; power of 2, at least 2*FETCH_HW.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush_i  input  1  redirect (branch taken, exception); dominates every other input.
REQ-006 flush_pc_i  input  32  redirect target; bit 0 ignored.
REQ-007 fetch_valid_i  input  1  fetch word present.
REQ-008 fetch_ready_o  output  1  buffer accepts the fetch word this cycle.
REQ-009 fetch_data_i  input  16*FETCH_HW  fetch word; halfword 0 at the lowest address.
REQ-010 inst_valid_o  output  1  a complete instruction is at the head.
REQ-011 inst_ready_i  input  1  consumer takes the head instruction.
REQ-012 inst_o  output  32  head instruction; compressed instructions zero-extended to 32 bits.
REQ-013 inst_pc_o  output  32  address of the head instruction.
REQ-014 inst_is_comp_o  output  1  head instruction is 16-bit.
REQ-015 count_o  output  $clog2(DEPTH_HW)+1  occupied halfwords.

Function
REQ-016 Storage SHALL be a circular halfword FIFO; read and write pointers are $clog2(DEPTH_HW)+1 bits and wrap modulo 2*DEPTH_HW.
REQ-017 Full/empty SHALL be derived from pointer difference; count_o equals write pointer minus read pointer.
REQ-018 fetch_ready_o = !flush_i && (DEPTH_HW - count_o >= FETCH_HW), computed from registered state only.
REQ-019 Push accepted when fetch_valid_i && fetch_ready_o; all FETCH_HW halfwords are written except those skipped per REQ-024.
REQ-020 Head length: head halfword bits [1:0] != 2'b11 means compressed, needs 1 halfword; otherwise needs 2.
REQ-021 inst_valid_o = count_o >= needed halfwords; the upper halfword of a 32-bit instruction SHALL come from the next FIFO slot, including across pointer wrap.
REQ-022 Pop on inst_valid_o && inst_ready_i; read pointer advances 1 or 2 and inst_pc_o advances 2 or 4.
REQ-023 Push and pop in the same cycle SHALL both take effect; count_o updates by pushed minus popped.
REQ-024 Flush SHALL empty the FIFO, drop any same-cycle push, set inst_pc_o to {flush_pc_i[31:1],1'b0}, and arm skip = flush_pc_i[$clog2(2*FETCH_HW)-1:1].
REQ-025 The first push after a flush SHALL drop its lowest `skip` halfwords, then clear skip.
REQ-026 Latency: halfwords pushed in cycle N are visible at the head in cycle N+1; no combinational path from fetch_* to inst_*.
REQ-027 inst_valid_o SHALL be 0 in the cycle after flush_i; flush_i and a pop in the same cycle produce no pop.
REQ-028 When inst_valid_o is 0, inst_o, inst_pc_o and inst_is_comp_o SHALL hold their current values; inst_o and inst_is_comp_o need not be meaningful.

Reset
REQ-029 On reset: pointers 0, count_o 0, skip 0, inst_pc_o 32'h0000_0000, inst_valid_o 0, fetch_ready_o 1 on the first cycle after reset.
REQ-030 Reset SHALL take priority over flush_i and any handshake; a partially buffered 32-bit instruction is discarded.

Configuration
REQ-031 Macro C_ALIGN_COMP_EN.
  - Defined: behaviour as above.
  - Undefined: every head is treated as 32-bit (needs 2 halfwords).
  - Undefined: inst_is_comp_o tied 0.
  - Undefined: flush_pc_i bit 1 treated as 0.
  - Undefined: inst_pc_o advances by 4 only.

Verification
REQ-032 Reset, then push {32'h0000_4501 lo=0x4501, hi=0x0000} at pc 0 -> next cycle inst_valid_o=1, inst_is_comp_o=1, inst_o=32'h0000_4501, inst_pc_o=0.
REQ-033 Flush to 0x102, then push word {hi=0x0093 (low half of 32-bit instr 0x00100093), lo=junk}, then push {hi=x, lo=0x0010} -> lo of first word dropped; inst_o=32'h0010_0093, inst_pc_o=0x102, is_comp=0, valid only after the second push.
REQ-034 Fill to count_o=DEPTH_HW with inst_ready_i=0 -> fetch_ready_o=0; then one compressed pop -> fetch_ready_o stays 0 until count_o <= DEPTH_HW-FETCH_HW.
REQ-035 Streaming push plus pop every cycle with mixed 16/32-bit stream across pointer wrap -> instruction sequence and PCs match a reference model, with no gaps after the first instruction.
REQ-036 flush_i asserted with fetch_valid_i=1 and inst_ready_i=1 -> no push, no pop, count_o=0 and inst_valid_o=0 next cycle.
REQ-037 Build without C_ALIGN_COMP_EN, push 0x4501/0x0000 -> inst_is_comp_o=0, inst_o=32'h0000_4501, inst_pc_o advances by 4.
